// File: rtl/write_port_arbiter_pkg.sv
// rtl/write_port_arbiter_pkg.sv - shared state encoding and on/off constants for the write port arbiter
package write_port_arbiter_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_WRITE = 1'b1;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic {
        IDLE  = STATE_IDLE,
        WRITE = STATE_WRITE
    } state_t;

endpackage

// File: rtl/write_port_arbiter_rr_pick.sv
// rtl/write_port_arbiter_rr_pick.sv - combinational round-robin picker starting one past the last grant
module rr_pick
    import write_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_SIZE = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_SIZE-1:0] i_last,
    output logic [ID_SIZE-1:0] o_winner,
    output logic               o_any_valid
);

    logic [ID_SIZE:0]   w_cand [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    // Candidate k is last+k+1; the sum is widened one bit so the wrap is modulo NUM_REQ.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        logic [ID_SIZE:0] w_sum;
        assign w_sum     = {1'b0, i_last} + (ID_SIZE+1)'(k + 1);
        assign w_cand[k] = (w_sum >= (ID_SIZE+1)'(NUM_REQ)) ? (w_sum - (ID_SIZE+1)'(NUM_REQ)) : w_sum;
        assign w_hit[k]  = |(i_valid & (NUM_REQ'(1) << w_cand[k]));
    end

    always_comb begin
        o_winner    = '0;
        o_any_valid = OFF;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_winner    = w_cand[k][ID_SIZE-1:0];
                o_any_valid = ON;
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// rtl/write_port_arbiter.sv - round-robin arbiter sharing one memory write port among store requesters
module write_port_arbiter
    import write_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int NUM_REQ      = 2,
    parameter int ID_SIZE      = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]    req_data,
    output logic [NUM_REQ-1:0]              req_ack,
    input  logic                            w_ready,
    output logic                            w_en,
    output logic [ADDRESS_SIZE-1:0]         w_addr,
    output logic [WORD_SIZE-1:0]            w_data,
    output logic [ID_SIZE-1:0]              grant_id,
    output logic                            busy
);

    state_t                  r_state;
    logic                    r_w_en;
    logic [ADDRESS_SIZE-1:0] r_w_addr;
    logic [WORD_SIZE-1:0]    r_w_data;
    logic [ID_SIZE-1:0]      r_grant_id;

    logic [ID_SIZE-1:0]      w_winner;
    logic                    w_any_valid;
    logic [ADDRESS_SIZE-1:0] w_sel_addr;
    logic [WORD_SIZE-1:0]    w_sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_SIZE (ID_SIZE)
    ) u_pick (
        .i_valid     (req_valid),
        .i_last      (r_grant_id),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_SIZE'(i)) begin
                w_sel_addr = req_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
                w_sel_data = req_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Grant index resets to the last requester so requester 0 is searched first.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_w_en     <= OFF;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_grant_id <= ID_SIZE'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id <= w_winner;
                        r_w_addr   <= w_sel_addr;
                        r_w_data   <= w_sel_data;
                        r_w_en     <= ON;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_ready) begin
                        r_w_en  <= OFF;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_w_en  <= OFF;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
        assign req_ack[i] = r_w_en & w_ready & (r_grant_id == ID_SIZE'(i));
    end

    assign w_en     = r_w_en;
    assign w_addr   = r_w_addr;
    assign w_data   = r_w_data;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == WRITE);

endmodule

// File: tb/tb_write_port_arbiter.sv
// tb/tb_write_port_arbiter.sv - scoreboard bench for the round-robin write port arbiter
module tb_write_port_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [7:0]  req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_ack;
    logic        w_ready;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [1:0]  grant_id;
    logic        busy;

    int   test_cnt;
    int   fail_cnt;
    exp_t sb[$];
    exp_t mon_e;

    write_port_arbiter #(
        .WORD_SIZE    (8),
        .ADDRESS_SIZE (4),
        .NUM_REQ      (2),
        .ID_SIZE      (2)
    ) dut (
        .clock     (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .w_ready   (w_ready),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted writes are popped from the scoreboard; any other cycle must show no ack.
    always begin
        @(negedge clk);
        #3;
        if (w_en === 1'b1 && w_ready === 1'b1) begin
            test_cnt++;
            if (sb.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_write: got id=%0d addr=%h data=%h, required none", grant_id, w_addr, w_data);
            end else begin
                mon_e = sb.pop_front();
                if ({grant_id, w_addr, w_data} !== {mon_e.id, mon_e.addr, mon_e.data}) begin
                    fail_cnt++;
                    $display("FAIL write_content: got id=%0d addr=%h data=%h, required id=%0d addr=%h data=%h",
                             grant_id, w_addr, w_data, mon_e.id, mon_e.addr, mon_e.data);
                end
                test_cnt++;
                if (req_ack !== (2'b01 << mon_e.id)) begin
                    fail_cnt++;
                    $display("FAIL ack_onehot: got %b, required %b", req_ack, 2'b01 << mon_e.id);
                end
            end
        end else begin
            test_cnt++;
            if (req_ack !== 2'b00) begin
                fail_cnt++;
                $display("FAIL spurious_ack: got %b, required 00", req_ack);
            end
        end
    end

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b11;
        req_addr  = {4'h3, 4'h1};
        req_data  = {8'h22, 8'h11};
        repeat (3) begin
            @(negedge clk); #1;
            test_cnt++;
            if (w_en !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b0 || w_addr !== 4'h0 || w_data !== 8'h00) begin
                fail_cnt++;
                $display("FAIL reset_state: got en=%b id=%0d busy=%b addr=%h data=%h, required 0 1 0 0 00",
                         w_en, grant_id, busy, w_addr, w_data);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        w_ready = 1'b1;
        sb.push_back('{id: 2'd0, addr: 4'h1, data: 8'h11});
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b1 || grant_id !== 2'd0) begin
            fail_cnt++;
            $display("FAIL reset_first_grant: got en=%b id=%0d, required en=1 id=0", w_en, grant_id);
        end
        req_valid = 2'b00;
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_release_done: got en=%b, required 0", w_en);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        w_ready       = 1'b0;
        req_valid     = 2'b01;
        req_addr[3:0] = 4'h9;
        req_data[7:0] = 8'h3C;
        sb.push_back('{id: 2'd0, addr: 4'h9, data: 8'h3C});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            test_cnt++;
            if (w_en !== 1'b1 || w_addr !== 4'h9 || w_data !== 8'h3C || req_ack !== 2'b00 || busy !== 1'b1) begin
                fail_cnt++;
                $display("FAIL stall_hold: got en=%b addr=%h data=%h ack=%b busy=%b, required 1 9 3c 00 1",
                         w_en, w_addr, w_data, req_ack, busy);
            end
        end
        w_ready = 1'b1;
        #1;
        test_cnt++;
        if (req_ack !== 2'b01) begin
            fail_cnt++;
            $display("FAIL stall_release_ack: got %b, required 01", req_ack);
        end
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b0 || req_ack !== 2'b00) begin
            fail_cnt++;
            $display("FAIL stall_single_ack: got en=%b ack=%b, required en=0 ack=00", w_en, req_ack);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid      = 2'b10;
        req_addr[7:4]  = 4'h5;
        req_data[15:8] = 8'hA3;
        w_ready        = 1'b1;
        sb.push_back('{id: 2'd1, addr: 4'h5, data: 8'hA3});
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b1 || w_addr !== 4'h5 || w_data !== 8'hA3 || req_ack !== 2'b10) begin
            fail_cnt++;
            $display("FAIL single_write: got en=%b addr=%h data=%h ack=%b, required 1 5 a3 10",
                     w_en, w_addr, w_data, req_ack);
        end
        req_valid = 2'b00;
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b0) begin
            fail_cnt++;
            $display("FAIL single_done: got en=%b, required 0", w_en);
        end
    endtask

    task automatic test_fairness();
        int cnt [2];
        int last_c;
        int acks;
        cnt[0] = 0;
        cnt[1] = 0;
        last_c = -1;
        acks   = 0;
        @(negedge clk);
        w_ready   = 1'b1;
        req_valid = 2'b11;
        req_addr  = {4'h9, 4'h8};
        req_data  = {8'h20, 8'h10};
        sb.push_back('{id: 2'd0, addr: 4'h8, data: 8'h10});
        sb.push_back('{id: 2'd1, addr: 4'h9, data: 8'h20});
        sb.push_back('{id: 2'd0, addr: 4'hA, data: 8'h11});
        sb.push_back('{id: 2'd1, addr: 4'hB, data: 8'h21});
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(negedge clk); #1;
            if (req_ack != 2'b00) begin
                acks++;
                if (last_c >= 0) begin
                    test_cnt++;
                    if (c - last_c != 2) begin
                        fail_cnt++;
                        $display("FAIL fair_spacing: got %0d cycles, required 2", c - last_c);
                    end
                end
                last_c = c;
                for (int i = 0; i < 2; i++) begin
                    if (req_ack[i]) begin
                        cnt[i]++;
                        if (cnt[i] == 2) begin
                            req_valid[i] = 1'b0;
                        end else begin
                            req_addr[i*4 +: 4] = (i == 0) ? 4'hA : 4'hB;
                            req_data[i*8 +: 8] = (i == 0) ? 8'h11 : 8'h21;
                        end
                    end
                end
            end
        end
        test_cnt++;
        if (acks != 4) begin
            fail_cnt++;
            $display("FAIL fair_ack_count: got %0d acks in budget, required 4", acks);
        end
    endtask

    task automatic test_late_arrival();
        @(negedge clk);
        w_ready        = 1'b0;
        req_valid      = 2'b10;
        req_addr[7:4]  = 4'h2;
        req_data[15:8] = 8'h55;
        sb.push_back('{id: 2'd1, addr: 4'h2, data: 8'h55});
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b1 || grant_id !== 2'd1) begin
            fail_cnt++;
            $display("FAIL late_first_grant: got en=%b id=%0d, required en=1 id=1", w_en, grant_id);
        end
        req_valid     = 2'b11;
        req_addr[3:0] = 4'h7;
        req_data[7:0] = 8'hE1;
        sb.push_back('{id: 2'd0, addr: 4'h7, data: 8'hE1});
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b1 || grant_id !== 2'd1 || w_addr !== 4'h2 || w_data !== 8'h55) begin
            fail_cnt++;
            $display("FAIL late_no_mix: got en=%b id=%0d addr=%h data=%h, required 1 1 2 55",
                     w_en, grant_id, w_addr, w_data);
        end
        w_ready = 1'b1;
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b0 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL late_idle_gap: got en=%b busy=%b, required 0 0", w_en, busy);
        end
        req_valid = 2'b01;
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b1 || grant_id !== 2'd0 || w_addr !== 4'h7 || w_data !== 8'hE1) begin
            fail_cnt++;
            $display("FAIL late_second_grant: got en=%b id=%0d addr=%h data=%h, required 1 0 7 e1",
                     w_en, grant_id, w_addr, w_data);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        w_ready       = 1'b0;
        req_valid     = 2'b01;
        req_addr[3:0] = 4'hC;
        req_data[7:0] = 8'h9D;
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b1 || grant_id !== 2'd0) begin
            fail_cnt++;
            $display("FAIL midrst_grant: got en=%b id=%0d, required en=1 id=0", w_en, grant_id);
        end
        reset_n = 1'b0;
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b0 || req_ack !== 2'b00) begin
            fail_cnt++;
            $display("FAIL midrst_abandon: got en=%b id=%0d busy=%b ack=%b, required 0 1 0 00",
                     w_en, grant_id, busy, req_ack);
        end
        w_ready   = 1'b1;
        req_valid = 2'b00;
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        test_cnt++;
        if (w_en !== 1'b0 || req_ack !== 2'b00) begin
            fail_cnt++;
            $display("FAIL midrst_no_replay: got en=%b ack=%b, required 0 00", w_en, req_ack);
        end
    endtask

    initial begin
        test_cnt  = 0;
        fail_cnt  = 0;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        w_ready   = 1'b0;
        test_reset();
        test_stall();
        test_single();
        test_fairness();
        test_late_arrival();
        test_reset_mid_write();
        @(negedge clk); #1;
        test_cnt++;
        if (sb.size() != 0) begin
            fail_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
